// File: rtl/ucore_pkg.sv
// Shared types and constants for the ucore memory responder.
// Response status encodings and the response record layout.
package ucore_pkg;

  localparam logic UCORE_RSP_OK  = 1'b0;
  localparam logic UCORE_RSP_ERR = 1'b1;

  localparam int UCORE_DATA_W = 32;

  typedef struct packed {
    logic                    err;
    logic [UCORE_DATA_W-1:0] rdata;
  } ucore_rsp_t;

endpackage

// File: rtl/ucore_mem_responder_if.sv
// Request/response bus between a ucore core and its memory responder.
// The master is the core; the slave is the responder.
interface ucore_mem_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_strb;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_write, req_addr,
    output req_wdata, req_strb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr,
    input  req_wdata, req_strb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_err
  );

endinterface

// File: rtl/ucore_rsp_fifo.sv
// Two-entry response FIFO with registered head outputs.
// Slot s0 is always the head, so dout comes straight from a flop.
module ucore_rsp_fifo
  import ucore_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         areset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] s0;
  logic [W-1:0] s1;
  logic [1:0]   cnt;
  logic         do_pop;
  logic         do_push;

  assign do_pop  = pop & (cnt != 2'd0);
  assign do_push = push & ((cnt != 2'd2) | do_pop);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      s0  <= '0;
      s1  <= '0;
      cnt <= 2'd0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) s0 <= din;
          else             s1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          s0  <= (cnt == 2'd2) ? s1 : '0;
          s1  <= '0;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd2) begin
            s0 <= s1;
            s1 <= din;
          end else begin
            s0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid = (cnt != 2'd0);
  assign dout  = s0;
  assign count = cnt;

endmodule

// File: rtl/ucore_mem_responder.sv
// Word-addressed memory responder for a ucore core.
// One in-flight stage feeds a 2-deep response FIFO; ordered responses.
module ucore_mem_responder
  import ucore_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  areset,
  ucore_mem_responder_if.slave  bus
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW    = DATA_W + 1;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc;
  logic              pop;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [RW-1:0]     rsp_d;
  logic [RW-1:0]     inflight_q;
  logic              inflight_v;
  logic [RW-1:0]     head;
  logic              fifo_valid;
  logic [1:0]        fifo_count;
  logic [2:0]        occ;

  assign in_range = {1'b0, bus.req_addr} < LIMIT;
  assign idx      = bus.req_addr[IDX_W-1:0];
  assign acc      = bus.req_valid & bus.req_ready;
  assign pop      = fifo_valid & bus.rsp_ready;
  assign occ      = {1'b0, fifo_count} + {2'b00, inflight_v};

  // rsp_ready feeds req_ready combinationally so a pop frees a slot now
  assign bus.req_ready = !areset &&
    ((occ - {2'b00, pop}) < 3'd2);

  always_comb begin
    rsp_d = {UCORE_RSP_OK, {DATA_W{1'b0}}};
    if (!in_range) begin
      rsp_d[DATA_W] = UCORE_RSP_ERR;
    end else if (!bus.req_write) begin
      rsp_d[DATA_W-1:0] = mem[idx];
    end
  end

  // Store is intentionally not reset
  always_ff @(posedge clk) begin
    if (acc && bus.req_write && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.req_strb[i]) begin
          mem[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      inflight_v <= 1'b0;
      inflight_q <= '0;
    end else begin
      inflight_v <= acc;
      if (acc) inflight_q <= rsp_d;
    end
  end

  ucore_rsp_fifo #(
    .W (RW)
  ) u_fifo (
    .clk    (clk),
    .areset (areset),
    .push   (inflight_v),
    .din    (inflight_q),
    .pop    (pop),
    .valid  (fifo_valid),
    .dout   (head),
    .count  (fifo_count)
  );

  assign bus.rsp_valid = fifo_valid;
  assign bus.rsp_err   = head[DATA_W];
  assign bus.rsp_rdata = head[DATA_W-1:0];

endmodule

// File: doc/ucore_mem_responder.md
# ucore_mem_responder

Request/response memory responder that sits on the far side of a generated `ucore_*` core's memory-access ports. It accepts read and write requests issued by microcode statements and returns one ordered response per request. Requests are served from a local word-addressed store. A 2-entry response buffer absorbs back-pressure, so the core's FSM can issue requests back-to-back without stalling.

## Interface
Parameters:
- `ADDR_W`, 8: request address width (word address).
- `DATA_W`, 32: data width; must be a multiple of 8.
- `DEPTH`, 256: implemented words, ≤ 2^ADDR_W; addresses ≥ DEPTH are out of range.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `areset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: word address.
- `req_wdata` in DATA_W: write data.
- `req_strb` in DATA_W/8: byte enables for writes; ignored on reads.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: core accepts response.
- `rsp_rdata` out DATA_W: read data; 0 for writes and errors.
- `rsp_err` out 1: out-of-range address.

## Operation
- Request handshake: `req_valid & req_ready` at a rising edge E.
- Response handshake: `rsp_valid & rsp_ready` at an edge.
- While `req_valid` is high and `req_ready` is low, the master holds all `req_*` stable. `rsp_*` is held stable while `rsp_valid & !rsp_ready`.
- Pipeline:
  - Stage A, edge E: address decode, memory write or read, result captured in the in-flight register (`inflight_v`).
  - Stage B, edge E+1: the in-flight result is pushed into the 2-entry response FIFO.
- Occupancy is `fifo_count + inflight_v`.
- `req_ready = (occupancy - pop) < 2`, where `pop = rsp_valid & rsp_ready`.
  - This is a deliberate combinational path from `rsp_ready` to `req_ready`.
  - Never more than 2 requests are outstanding.
- Writes:
  - Byte lanes with `req_strb[i]=1` are updated at E; other lanes are retained.
  - Response is `rdata=0`, `err=0`.
- Reads: data sampled at E, after any write committed at an earlier edge.
- Out of range (`req_addr ≥ DEPTH`):
  - The store is not modified.
  - Response is `rdata=0`, `err=1`.
- Ordering: responses are returned strictly in request order, one per request.
- Simultaneous push and pop on a non-empty FIFO: count unchanged, head advances.
- Push into an empty FIFO with `rsp_ready` high: the response is popped one edge after it appears. There is no bypass.
- Reset:
  - `inflight_v=0`, FIFO empty, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`.
  - `req_ready` is 1 from the first edge after release.
  - Store contents are not reset.
  - Reset mid-transaction discards all outstanding responses; pending writes already committed at E remain.

## Timing
- Latency: request accepted at edge E → `rsp_valid` high after edge E+1, i.e. 2 cycles.
- Throughput: 1 request/cycle while `rsp_ready` is held high.
- With `rsp_ready` low: at most 2 accepts, then `req_ready=0` until a pop.
- Read-after-write to the same address on consecutive edges returns the new data.

## Structure
- Shared package `ucore_pkg`:
  - `UCORE_RSP_OK`/`UCORE_RSP_ERR` constants.
  - The response struct type `{err, rdata}`.
- Sub-module `ucore_rsp_fifo`:
  - Parameterised width, fixed depth 2.
  - Push/pop, count, async active-high reset.
  - Registered head outputs.
- Top level holds the storage array, range decode, strobe merge and the in-flight register.

## Test plan
- Reset with `areset` high for 3 cycles, then release:
  - `rsp_valid=0`, `req_ready=1`.
  - No response ever appears without a request.
- Write `addr=5`, `wdata=0xDEADBEEF`, `strb=0xF`, then read `addr=5` on the next cycle, `rsp_ready=1`:
  - Two responses in order: `(0,0)` then `(0xDEADBEEF,0)`.
  - The second appears 2 cycles after its request.
- Partial strobe: `addr=5` holds `0xDEADBEEF`; write `0x11223344` with `strb=0x5`, then read `addr=5`: expect `0xDE22BE44`.
- Back-pressure: `rsp_ready=0`, issue 4 reads:
  - Exactly 2 are accepted, then `req_ready=0`.
  - Raise `rsp_ready`: the remaining 2 are accepted as slots free, 4 responses arrive in order, none lost or duplicated.
- Out of range with `DEPTH=256`, `ADDR_W=9`: write to `addr=300`, then read `addr=300`:
  - Both responses have `err=1` and `rdata=0`.
  - Reading `addr=44` (low bits of 300) is unchanged.
- Reset with 2 responses buffered, assert `areset` mid-stream:
  - `rsp_valid` drops immediately (asynchronous reset).
  - After release, new requests are serviced normally.
